// File: rtl/regfile_wport_arb_pkg.sv
`default_nettype none
// ============================================================================
//  regfile_arb_pkg
//  Shared types and constants for the register-file writeback port arbiter.
//  Revision: 1.0
// ============================================================================
package regfile_arb_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  localparam int         NUM_REQ  = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/regfile_wport_arb_if.sv
`default_nettype none
// ============================================================================
//  regfile_wport_arb_if
//  Writeback request channels, register-file write port, hazard query and
//  conflict counter of the writeback arbiter.
//  Revision: 1.0
// ============================================================================
interface regfile_wport_arb_if #(
  parameter int CNT_W = 16
);

  logic             req0_val;
  logic             req0_rdy;
  logic [4:0]       req0_addr;
  logic [31:0]      req0_data;
  logic             req1_val;
  logic             req1_rdy;
  logic [4:0]       req1_addr;
  logic [31:0]      req1_data;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [4:0]       q_addr;
  logic             q_busy;
  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  req0_val, req0_addr, req0_data,
    input  req1_val, req1_addr, req1_data,
    input  q_addr,
    output req0_rdy, req1_rdy,
    output rf_wen, rf_waddr, rf_wdata,
    output q_busy, conflict_cnt
  );

  modport master (
    output req0_val, req0_addr, req0_data,
    output req1_val, req1_addr, req1_data,
    output q_addr,
    input  req0_rdy, req1_rdy,
    input  rf_wen, rf_waddr, rf_wdata,
    input  q_busy, conflict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wport_arb_wb_buf.sv
`default_nettype none
// ============================================================================
//  wb_buf
//  One-entry writeback holding buffer with val/rdy fill and grant drain.
//  Revision: 1.0
// ============================================================================
module wb_buf
  import regfile_arb_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    i_fill_val,
  input  wire wb_req_t i_fill,
  output logic         o_fill_rdy,
  input  wire logic    i_grant,
  output logic         o_val,
  output wb_req_t      o_entry,
  output logic         o_filled
);

  logic    r_val;
  wb_req_t r_entry;
  logic    w_acc;

  // A granted entry leaves at this edge, so the slot can be refilled now.
  assign o_fill_rdy = ~rst & (~r_val | i_grant);
  assign w_acc      = i_fill_val & o_fill_rdy;
  assign o_filled   = w_acc & (i_fill.addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= 1'b0;
      r_entry <= '0;
    end else if (o_filled) begin
      r_val   <= 1'b1;
      r_entry <= i_fill;
    end else if (i_grant) begin
      r_val   <= 1'b0;
    end
  end

  assign o_val   = r_val;
  assign o_entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/regfile_wport_arb.sv
`default_nettype none
// ============================================================================
//  regfile_wport_arb
//  Arbitrates the X-stage ALU (req0) and M-stage load (req1) writebacks onto
//  a single register-file write port through one-entry holding buffers.
//  Build option: REGFILE_WPORT_ARB_RR_EN selects round-robin arbitration;
//  otherwise req1 has fixed priority over req0.
//  Revision: 1.0
// ============================================================================
module regfile_wport_arb
  import regfile_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  regfile_wport_arb_if.slave  bus
);

  logic [NUM_REQ-1:0] w_req_val;
  wb_req_t            w_req   [NUM_REQ];
  logic [NUM_REQ-1:0] w_rdy;
  logic [NUM_REQ-1:0] w_val;
  wb_req_t            w_entry [NUM_REQ];
  logic [NUM_REQ-1:0] w_filled;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_nval;
  logic               w_both;
  logic               w_same;

  logic               r_age1;
  logic [CNT_W-1:0]   r_cnt;

  assign w_req_val[0] = bus.req0_val;
  assign w_req_val[1] = bus.req1_val;
  assign w_req[0]     = '{addr: bus.req0_addr, data: bus.req0_data};
  assign w_req[1]     = '{addr: bus.req1_addr, data: bus.req1_data};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
    wb_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .i_fill_val (w_req_val[gi]),
      .i_fill     (w_req[gi]),
      .o_fill_rdy (w_rdy[gi]),
      .i_grant    (w_grant[gi]),
      .o_val      (w_val[gi]),
      .o_entry    (w_entry[gi]),
      .o_filled   (w_filled[gi])
    );
  end

  assign bus.req0_rdy = w_rdy[0];
  assign bus.req1_rdy = w_rdy[1];

  assign w_both = w_val[0] & w_val[1];
  assign w_same = (w_entry[0].addr == w_entry[1].addr);

`ifdef REGFILE_WPORT_ARB_RR_EN
  logic r_rr_pri1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_pri1 <= 1'b0;
    end else if (w_both) begin
      r_rr_pri1 <= w_grant[0];
    end
  end
`endif

  // Same-destination entries must retire oldest-first so the younger value
  // is the one left in the register file.
  always_comb begin
    w_grant = '0;
    if (!rst) begin
      if (w_both) begin
        if (w_same) begin
          w_grant = r_age1 ? 2'b10 : 2'b01;
        end else begin
`ifdef REGFILE_WPORT_ARB_RR_EN
          w_grant = r_rr_pri1 ? 2'b10 : 2'b01;
`else
          w_grant = 2'b10;
`endif
        end
      end else begin
        w_grant = w_val;
      end
    end
  end

  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = REG_ZERO;
    bus.rf_wdata = 32'd0;
    if (w_grant[1]) begin
      bus.rf_wen   = 1'b1;
      bus.rf_waddr = w_entry[1].addr;
      bus.rf_wdata = w_entry[1].data;
    end else if (w_grant[0]) begin
      bus.rf_wen   = 1'b1;
      bus.rf_waddr = w_entry[0].addr;
      bus.rf_wdata = w_entry[0].data;
    end
  end

  // r_age1 set means buf1 holds the older of the two entries.
  assign w_nval = w_filled | (w_val & ~w_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age1 <= 1'b0;
    end else if (w_filled[0] && w_filled[1]) begin
      r_age1 <= 1'b1;
    end else if (w_filled[1]) begin
      r_age1 <= ~w_nval[0];
    end else if (w_filled[0]) begin
      r_age1 <= w_nval[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_both && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.conflict_cnt = r_cnt;

  assign bus.q_busy = ~rst & (bus.q_addr != REG_ZERO) &
                      ((w_val[0] & (w_entry[0].addr == bus.q_addr)) |
                       (w_val[1] & (w_entry[1].addr == bus.q_addr)));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arb.sv
`default_nettype none
// ============================================================================
//  tb_regfile_wport_arb
//  Directed scenarios plus randomized traffic against an age-ordered model.
//  Revision: 1.0
// ============================================================================
module tb_regfile_wport_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wport_arb_if #(.CNT_W(16)) bus ();

  regfile_wport_arb #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: each slot carries a fill sequence number; smaller means older.
  bit          m_val  [2] = '{0, 0};
  logic [4:0]  m_addr [2] = '{5'd0, 5'd0};
  logic [31:0] m_data [2] = '{32'd0, 32'd0};
  int          m_seq  [2] = '{0, 0};
  int          m_seq_ctr  = 0;
  int          m_cnt      = 0;
  int          m_last_win = 1;
  logic [31:0] obs_rf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] q);
    int       g;
    bit       rdy [2];
    bit       busy;
    bit       vin [2];
    logic [4:0]  ain [2];
    logic [31:0] din [2];
    @(negedge clk);
    rst = r;
    bus.req0_val = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_val = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.q_addr = q;
    vin = '{v0, v1}; ain = '{a0, a1}; din = '{d0, d1};
    #1;
    g = -1;
    if (!r) begin
      if (m_val[0] && m_val[1]) begin
        if (m_addr[0] == m_addr[1]) g = (m_seq[1] < m_seq[0]) ? 1 : 0;
`ifdef REGFILE_WPORT_ARB_RR_EN
        else g = 1 - m_last_win;
`else
        else g = 1;
`endif
      end else if (m_val[0]) g = 0;
      else if (m_val[1]) g = 1;
    end
    for (int n = 0; n < 2; n++) rdy[n] = !r && (!m_val[n] || g == n);
    busy = !r && (q != 5'd0) && ((m_val[0] && m_addr[0] == q) || (m_val[1] && m_addr[1] == q));

    chk("rf_wen",   {31'd0, bus.rf_wen}, {31'd0, g >= 0});
    chk("rf_waddr", {27'd0, bus.rf_waddr}, (g >= 0) ? {27'd0, m_addr[g]} : 32'd0);
    chk("rf_wdata", bus.rf_wdata, (g >= 0) ? m_data[g] : 32'd0);
    chk("req0_rdy", {31'd0, bus.req0_rdy}, {31'd0, rdy[0]});
    chk("req1_rdy", {31'd0, bus.req1_rdy}, {31'd0, rdy[1]});
    chk("q_busy",   {31'd0, bus.q_busy}, {31'd0, busy});
    if (!r) chk("conflict_cnt", {16'd0, bus.conflict_cnt}, m_cnt);
    if (bus.rf_wen === 1'b1) obs_rf[bus.rf_waddr] = bus.rf_wdata;

    if (r) begin
      m_val = '{0, 0};
      m_cnt = 0;
      m_last_win = 1;
    end else begin
      if (m_val[0] && m_val[1]) begin
        if (m_cnt < 65535) m_cnt++;
        m_last_win = g;
      end
      for (int n = 0; n < 2; n++) begin
        if (vin[n] && rdy[n] && ain[n] != 5'd0) begin
          m_val[n]  = 1;
          m_addr[n] = ain[n];
          m_data[n] = din[n];
          m_seq[n]  = m_seq_ctr + ((n == 0) ? 1 : 0);
        end else if (g == n) begin
          m_val[n] = 0;
        end
      end
      m_seq_ctr += 2;
    end
  endtask

  task automatic idle(input logic [4:0] q);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, q);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) obs_rf[i] = 32'd0;
    bus.req0_val = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_val = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.q_addr = 0;

    step(1, 1, 5'd6, 32'h1234, 1, 5'd8, 32'h5678, 5'd6);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
    idle(5'd6);
    chk("rst_busy", {31'd0, bus.q_busy}, 32'd0);
    chk("rst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);

    // Single ALU write, no contention
    step(0, 1, 5'd5, 32'hAAAA0001, 0, 5'd0, 32'd0, 5'd5);
    idle(5'd5);
    chk("single_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("single_waddr", {27'd0, bus.rf_waddr}, 32'd5);
    chk("single_wdata", bus.rf_wdata, 32'hAAAA0001);
    idle(5'd5);
    chk("single_empty", {31'd0, bus.q_busy}, 32'd0);

    // Different destinations, same cycle
    step(0, 1, 5'd3, 32'h31, 1, 5'd7, 32'h37, 5'd0);
    idle(5'd0);
`ifdef REGFILE_WPORT_ARB_RR_EN
    chk("diff_first", {27'd0, bus.rf_waddr}, 32'd3);
    idle(5'd0);
    chk("diff_second", {27'd0, bus.rf_waddr}, 32'd7);
`else
    chk("diff_first", {27'd0, bus.rf_waddr}, 32'd7);
    idle(5'd0);
    chk("diff_second", {27'd0, bus.rf_waddr}, 32'd3);
`endif
    chk("diff_cnt", {16'd0, bus.conflict_cnt}, 32'd1);

    // Same destination, same cycle: load is older
    step(0, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2, 5'd9);
    idle(5'd9);
    chk("same_first", bus.rf_wdata, 32'h2);
    idle(5'd9);
    chk("same_second", bus.rf_wdata, 32'h1);
    idle(5'd9);
    chk("same_final", obs_rf[9], 32'h1);

    // Write to x0 is dropped
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF, 5'd0);
    chk("zero_rdy", {31'd0, bus.req1_rdy}, 32'd1);
    idle(5'd0);
    chk("zero_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("zero_busy", {31'd0, bus.q_busy}, 32'd0);
    chk("zero_rdy2", {31'd0, bus.req1_rdy}, 32'd1);

    // Hazard query held until the write cycle
    step(0, 1, 5'd4, 32'h44, 1, 5'd10, 32'h10, 5'd4);
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      idle(5'd4);
      chk("haz_busy", {31'd0, bus.q_busy}, 32'd1);
      if (bus.rf_wen === 1'b1 && bus.rf_waddr === 5'd4) found = 1;
    end
    chk("haz_written", {31'd0, found}, 32'd1);
    idle(5'd4);
    chk("haz_clear", {31'd0, bus.q_busy}, 32'd0);

    // Reset with two entries buffered
    step(0, 1, 5'd12, 32'hC, 1, 5'd13, 32'hD, 5'd12);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12);
    chk("mrst_wen0", {31'd0, bus.rf_wen}, 32'd0);
    idle(5'd12);
    chk("mrst_wen1", {31'd0, bus.rf_wen}, 32'd0);
    chk("mrst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    idle(5'd13);
    chk("mrst_wen2", {31'd0, bus.rf_wen}, 32'd0);
    chk("mrst_busy", {31'd0, bus.q_busy}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
